// File: rtl/fdiv_pkg.sv
// Shared types, constants and operand classification for the divider request sequencer.
package fdiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        START,
        WAIT,
        CAPTURE,
        DRAIN
    } state_e;

    typedef enum logic [2:0] {
        ZERO,
        SUB,
        NORM,
        INF,
        NAN
    } op_class_e;

    localparam logic [31:0] QNAN_DEFAULT = 32'h7FC0_0000;

    localparam int INVALID   = 0;
    localparam int DIVBYZERO = 1;
    localparam int OVERFLOW  = 2;
    localparam int TIMEOUT   = 3;

    function automatic op_class_e classify(input logic [31:0] x);
        op_class_e c;
        if (x[30:23] == 8'hFF) begin
            if (x[22:0] == 23'd0) c = INF;
            else                  c = NAN;
        end else if (x[30:23] == 8'h00) begin
            if (x[22:0] == 23'd0) c = ZERO;
            else                  c = SUB;
        end else begin
            c = NORM;
        end
        return c;
    endfunction

endpackage

// File: rtl/fdiv_rsp_fifo.sv
// Two-entry response FIFO; a push is accepted while full if a pop happens in the same cycle.
module fdiv_rsp_fifo #(
    parameter int W = 40
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_full
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_do_pop;
    logic         w_do_push;

    assign w_do_pop  = i_pop & (r_count != 2'd0);
    assign w_do_push = i_push & ((r_count != 2'd2) | w_do_pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != 2'd0);
    assign o_full  = (r_count == 2'd2);

endmodule

// File: rtl/fdiv_req_seq.sv
// Request sequencer for the binary32 divider core: special operands resolved locally,
// finite pairs issued to the core with start/busy watchdogs, results queued in a 2-entry buffer.
//
// state   | meaning
// IDLE    | accept requests; special operands answered on the accept edge
// ISSUE   | core enabled, operands presented
// START   | one-cycle core_start pulse
// WAIT    | watch busy rise (START_WAIT) then fall (TIMEOUT_CYCLES)
// CAPTURE | write core result to the buffer
// DRAIN   | core abandoned after timeout; wait for busy to clear
module fdiv_req_seq
    import fdiv_pkg::*;
#(
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int START_WAIT     = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [31:0]      i_req_a,
    input  logic [31:0]      i_req_b,
    input  logic [TAG_W-1:0] i_req_tag,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [31:0]      o_rsp_z,
    output logic [TAG_W-1:0] o_rsp_tag,
    output logic [3:0]       o_rsp_flags,
    output logic [31:0]      o_core_a,
    output logic [31:0]      o_core_b,
    output logic             o_core_enable,
    output logic             o_core_start,
    input  logic             i_core_busy,
    input  logic [31:0]      i_core_z
);

    localparam int ENT_W   = 32 + TAG_W + 4;
    localparam int CNT_MAX = (TIMEOUT_CYCLES > START_WAIT) ? TIMEOUT_CYCLES : START_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_e           r_state;
    logic [TAG_W-1:0] r_tag;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy_seen;
    logic             r_tmo_pend;

    op_class_e        w_cls_a;
    op_class_e        w_cls_b;
    logic             w_sign;
    logic             w_fast;
    logic [31:0]      w_fast_z;
    logic [3:0]       w_fast_flags;
    logic             w_accept;
    logic             w_full;
    logic             w_pop;
    logic             w_can_push;
    logic             w_tmo;
    logic             w_push;
    logic [ENT_W-1:0] w_push_data;
    logic [ENT_W-1:0] w_head;

    always_comb begin
        w_cls_a      = classify(i_req_a);
        w_cls_b      = classify(i_req_b);
        w_sign       = i_req_a[31] ^ i_req_b[31];
        w_fast       = 1'b1;
        w_fast_z     = QNAN_DEFAULT;
        w_fast_flags = 4'b0000;
        if (w_cls_a == NAN) begin
            w_fast_z              = i_req_a | 32'h0040_0000;
            w_fast_flags[INVALID] = 1'b1;
        end else if (w_cls_b == NAN) begin
            w_fast_z              = i_req_b | 32'h0040_0000;
            w_fast_flags[INVALID] = 1'b1;
        end else if ((w_cls_a == ZERO && w_cls_b == ZERO) || (w_cls_a == INF && w_cls_b == INF)) begin
            w_fast_z              = QNAN_DEFAULT;
            w_fast_flags[INVALID] = 1'b1;
        end else if (w_cls_a == INF) begin
            // inf/0 lands here too: zero is finite, so no divide-by-zero flag
            w_fast_z = {w_sign, 8'hFF, 23'd0};
        end else if (w_cls_b == ZERO) begin
            w_fast_z                = {w_sign, 8'hFF, 23'd0};
            w_fast_flags[DIVBYZERO] = 1'b1;
        end else if (w_cls_a == ZERO || w_cls_b == INF) begin
            w_fast_z = {w_sign, 31'd0};
        end else begin
            w_fast = 1'b0;
        end
    end

    assign o_req_ready = (r_state == IDLE) & ~w_full & ~i_core_busy & ~i_rst;
    assign w_accept    = i_req_valid & o_req_ready;
    assign w_pop       = o_rsp_valid & i_rsp_ready;
    assign w_can_push  = ~w_full | w_pop;
    assign w_tmo       = (r_state == WAIT) &
                         (r_tmo_pend | ((r_cnt == '0) & (r_busy_seen ? i_core_busy : ~i_core_busy)));

    always_comb begin
        w_push      = 1'b0;
        w_push_data = '0;
        case (r_state)
            IDLE: begin
                w_push      = w_accept & w_fast;
                w_push_data = {w_fast_z, i_req_tag, w_fast_flags};
            end
            WAIT: begin
                w_push      = w_tmo & w_can_push;
                w_push_data = {QNAN_DEFAULT, r_tag, 4'b1000};
            end
            CAPTURE: begin
                w_push      = w_can_push;
                w_push_data = {i_core_z, r_tag, 1'b0, (i_core_z[30:23] == 8'hFF), 2'b00};
            end
            default: begin
                w_push      = 1'b0;
                w_push_data = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_tag         <= '0;
            r_cnt         <= '0;
            r_busy_seen   <= 1'b0;
            r_tmo_pend    <= 1'b0;
            o_core_a      <= '0;
            o_core_b      <= '0;
            o_core_enable <= 1'b0;
            o_core_start  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && !w_fast) begin
                        o_core_a      <= i_req_a;
                        o_core_b      <= i_req_b;
                        r_tag         <= i_req_tag;
                        o_core_enable <= 1'b1;
                        r_state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    o_core_start <= 1'b1;
                    r_state      <= START;
                end
                START: begin
                    o_core_start <= 1'b0;
                    r_cnt        <= CNT_W'(START_WAIT - 1);
                    r_busy_seen  <= 1'b0;
                    r_tmo_pend   <= 1'b0;
                    r_state      <= WAIT;
                end
                WAIT: begin
                    if (w_tmo) begin
                        if (w_can_push) begin
                            r_tmo_pend    <= 1'b0;
                            o_core_enable <= 1'b0;
                            r_state       <= DRAIN;
                        end else begin
                            r_tmo_pend <= 1'b1;
                        end
                    end else if (!r_busy_seen) begin
                        if (i_core_busy) begin
                            r_busy_seen <= 1'b1;
                            r_cnt       <= CNT_W'(TIMEOUT_CYCLES - 1);
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end else if (!i_core_busy) begin
                        r_state <= CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    if (w_can_push) begin
                        o_core_enable <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                DRAIN: begin
                    if (!i_core_busy) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    fdiv_rsp_fifo #(.W(ENT_W)) u_rsp_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_valid (o_rsp_valid),
        .o_full  (w_full)
    );

    assign o_rsp_z     = w_head[ENT_W-1 -: 32];
    assign o_rsp_tag   = w_head[4 +: TAG_W];
    assign o_rsp_flags = w_head[3:0];

endmodule

// File: tb/tb_fdiv_req_seq.sv
// Directed bench for fdiv_req_seq: special-operand table, core-path latency, backpressure,
// timeout recovery and reset during an in-flight operation.
module tb_fdiv_req_seq;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [31:0]      req_a = '0;
    logic [31:0]      req_b = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [31:0]      rsp_z;
    logic [TAG_W-1:0] rsp_tag;
    logic [3:0]       rsp_flags;
    logic [31:0]      core_a;
    logic [31:0]      core_b;
    logic             core_enable;
    logic             core_start;
    logic             core_busy = 1'b0;
    logic [31:0]      core_z = '0;

    always #5 clk = ~clk;

    fdiv_req_seq #(.TAG_W(TAG_W), .TIMEOUT_CYCLES(64), .START_WAIT(4)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_a       (req_a),
        .i_req_b       (req_b),
        .i_req_tag     (req_tag),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_z       (rsp_z),
        .o_rsp_tag     (rsp_tag),
        .o_rsp_flags   (rsp_flags),
        .o_core_a      (core_a),
        .o_core_b      (core_b),
        .o_core_enable (core_enable),
        .o_core_start  (core_start),
        .i_core_busy   (core_busy),
        .i_core_z      (core_z)
    );

    // Core model: busy rises the edge after start, stays high busy_len cycles (or while hung).
    logic        model_hang = 1'b0;
    int          busy_len   = 8;
    int          busy_left  = 0;
    logic [31:0] model_z    = '0;
    int          start_cnt  = 0;

    always @(posedge clk) begin
        if (core_start && core_enable) begin
            core_busy <= 1'b1;
            busy_left <= busy_len - 1;
        end else if (core_busy && !model_hang) begin
            if (busy_left == 0) begin
                core_busy <= 1'b0;
                core_z    <= model_z;
            end else begin
                busy_left <= busy_left - 1;
            end
        end
    end

    always @(posedge clk) if (core_start) start_cnt <= start_cnt + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int max_cyc, output int lat);
        lat = -1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic core_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] zm,
                           input int blen, input logic [3:0] tag,
                           input logic [31:0] exp_z, input logic [3:0] exp_fl, input string nm);
        int s0;
        int lat;
        model_z  = zm;
        busy_len = blen;
        s0       = start_cnt;
        req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
        @(negedge clk);
        chk({nm, " ready"}, 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk({nm, " issue enable"}, 32'(core_enable), 32'd1);
        chk({nm, " issue start"}, 32'(core_start), 32'd0);
        chk({nm, " core_a"}, core_a, a);
        chk({nm, " core_b"}, core_b, b);
        @(negedge clk);
        chk({nm, " start pulse"}, 32'(core_start), 32'd1);
        wait_rsp(blen + 20, lat);
        chk({nm, " latency"}, 32'(lat + 2), 32'(blen + 5));
        chk({nm, " z"}, rsp_z, exp_z);
        chk({nm, " tag"}, 32'(rsp_tag), 32'(tag));
        chk({nm, " flags"}, 32'(rsp_flags), 32'(exp_fl));
        chk({nm, " start count"}, 32'(start_cnt - s0), 32'd1);
        tick();
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        logic [3:0]  fl;
    } vec_t;

    vec_t vecs [14];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int lat;
        int got;

        vecs[0]  = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0010};
        vecs[1]  = '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b0001};
        vecs[2]  = '{32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0001, 4'b0001};
        vecs[3]  = '{32'h3F80_0000, 32'hFF81_2345, 32'hFFC1_2345, 4'b0001};
        vecs[4]  = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 4'b0001};
        vecs[5]  = '{32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000};
        vecs[6]  = '{32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 4'b0000};
        vecs[7]  = '{32'h4040_0000, 32'h7F80_0000, 32'h0000_0000, 4'b0000};
        vecs[8]  = '{32'hC040_0000, 32'h0000_0000, 32'hFF80_0000, 4'b0010};
        vecs[9]  = '{32'h8000_0000, 32'h7F80_0000, 32'h8000_0000, 4'b0000};
        vecs[10] = '{32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0000};
        vecs[11] = '{32'h8000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b0001};
        vecs[12] = '{32'h7FA0_0000, 32'h7F80_0005, 32'h7FE0_0000, 4'b0001};
        vecs[13] = '{32'h0000_0001, 32'h0000_0000, 32'h7F80_0000, 4'b0010};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_z", rsp_z, 32'd0);
        chk("reset rsp_tag", 32'(rsp_tag), 32'd0);
        chk("reset rsp_flags", 32'(rsp_flags), 32'd0);
        chk("reset core_enable", 32'(core_enable), 32'd0);
        chk("reset core_start", 32'(core_start), 32'd0);
        chk("reset core_a", core_a, 32'd0);
        chk("reset core_b", core_b, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset req_ready", 32'(req_ready), 32'd1);
        tick();

        // special operands: one-cycle response, core untouched
        s0 = start_cnt;
        for (int i = 0; i < 14; i++) begin
            req_a = vecs[i].a; req_b = vecs[i].b; req_tag = 4'(i); req_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("vec%0d ready", i), 32'(req_ready), 32'd1);
            tick();
            req_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("vec%0d z", i), rsp_z, vecs[i].z);
            chk($sformatf("vec%0d tag", i), 32'(rsp_tag), 32'(i));
            chk($sformatf("vec%0d flags", i), 32'(rsp_flags), 32'(vecs[i].fl));
            tick();
        end
        chk("fast path no core_start", 32'(start_cnt - s0), 32'd0);

        core_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 8, 4'd7, 32'h4040_0000, 4'b0000, "6/2");
        core_op(32'h7F00_0000, 32'h3F00_0000, 32'h7F80_0000, 3, 4'd9, 32'h7F80_0000, 4'b0100, "ovf");
        core_op(32'h0000_0001, 32'h3F80_0000, 32'h0000_0001, 2, 4'd4, 32'h0000_0001, 4'b0000, "subnorm");

        // backpressure: two buffered, third waits for a free slot
        rsp_ready = 1'b0;
        req_a = 32'h0; req_b = 32'h0; req_tag = 4'd1; req_valid = 1'b1;
        @(negedge clk);
        chk("bp ready tag1", 32'(req_ready), 32'd1);
        tick();
        req_tag = 4'd2;
        @(negedge clk);
        chk("bp ready tag2", 32'(req_ready), 32'd1);
        tick();
        req_tag = 4'd3;
        @(negedge clk);
        chk("bp full ready", 32'(req_ready), 32'd0);
        chk("bp head tag1", 32'(rsp_tag), 32'd1);
        tick();
        @(negedge clk);
        chk("bp still blocked", 32'(req_ready), 32'd0);
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp pop tag1", 32'(rsp_tag), 32'd1);
        chk("bp blocked at pop", 32'(req_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("bp ready after pop", 32'(req_ready), 32'd1);
        chk("bp tag2", 32'(rsp_tag), 32'd2);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("bp valid tag3", 32'(rsp_valid), 32'd1);
        chk("bp tag3", 32'(rsp_tag), 32'd3);
        chk("bp z tag3", rsp_z, 32'h7FC0_0000);
        chk("bp flags tag3", 32'(rsp_flags), 32'd1);
        tick();
        @(negedge clk);
        chk("bp empty", 32'(rsp_valid), 32'd0);
        tick();

        // back-to-back fast path while draining
        for (int i = 0; i < 5; i++) begin
            req_a = 32'h3F80_0000; req_b = 32'h0; req_tag = 4'(i + 8); req_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("b2b ready %0d", i), 32'(req_ready), 32'd1);
            if (i > 0) begin
                chk($sformatf("b2b valid %0d", i), 32'(rsp_valid), 32'd1);
                chk($sformatf("b2b tag %0d", i), 32'(rsp_tag), 32'(i + 7));
            end
            tick();
        end
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b last valid", 32'(rsp_valid), 32'd1);
        chk("b2b last tag", 32'(rsp_tag), 32'd12);
        tick();

        // hung core: busy never falls
        model_hang = 1'b1;
        busy_len   = 1;
        req_a = 32'h40C0_0000; req_b = 32'h4000_0000; req_tag = 4'd5; req_valid = 1'b1;
        @(negedge clk);
        chk("tmo ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        wait_rsp(100, lat);
        chk("tmo latency", 32'(lat), 32'd68);
        chk("tmo z", rsp_z, 32'h7FC0_0000);
        chk("tmo flags", 32'(rsp_flags), 32'b1000);
        chk("tmo tag", 32'(rsp_tag), 32'd5);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("tmo drain ready %0d", i), 32'(req_ready), 32'd0);
            chk($sformatf("tmo drain enable %0d", i), 32'(core_enable), 32'd0);
            tick();
        end
        model_hang = 1'b0;
        got = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1;
                break;
            end
        end
        chk("tmo recover ready", 32'(got), 32'd1);
        tick();

        // reset while waiting on the core
        model_hang = 1'b1;
        busy_len   = 1;
        req_a = 32'h40C0_0000; req_b = 32'h4000_0000; req_tag = 4'd6; req_valid = 1'b1;
        @(negedge clk);
        chk("rstw ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rstw ready in reset", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rstw busy ready %0d", i), 32'(req_ready), 32'd0);
            chk($sformatf("rstw no rsp %0d", i), 32'(rsp_valid), 32'd0);
            tick();
        end
        model_hang = 1'b0;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("rstw ready after busy", 32'(req_ready), 32'd1);
        chk("rstw no rsp after", 32'(rsp_valid), 32'd0);
        chk("rstw enable", 32'(core_enable), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fdiv_req_seq.md
# fdiv_req_seq

Request sequencer in front of the single-precision floating-point divider core (`divider`). It accepts tagged divide requests over a valid/ready handshake and resolves IEEE-754 special operands (NaN, ∞, zero) itself in one cycle. Finite non-zero operand pairs go to the core through its `enable`/`start`/`busy` protocol. Results are returned through a 2-entry response buffer with exception flags, and the sequencer recovers cleanly from a hung core.

## Interface
- `TAG_W`, 4 — request/response tag width
- `TIMEOUT_CYCLES`, 64 — max cycles `core_busy` may stay high
- `START_WAIT`, 4 — max cycles after `core_start` for `core_busy` to rise
- `clk` in 1 — the single clock; all state updates on rising edge
- `rst` in 1 — synchronous, active-high reset
- `req_valid` in 1 / `req_ready` out 1 — request handshake
- `req_a`, `req_b` in 32 — dividend and divisor (IEEE-754 binary32)
- `req_tag` in TAG_W — request tag, echoed on response
- `rsp_valid` out 1 / `rsp_ready` in 1 — response handshake
- `rsp_z` out 32 — quotient
- `rsp_tag` out TAG_W — tag of this response
- `rsp_flags` out 4 — {timeout, overflow, divbyzero, invalid}
- `core_a`, `core_b` out 32 — operands to core, held stable ISSUE..CAPTURE
- `core_enable` out 1, `core_start` out 1 — core controls
- `core_busy` in 1, `core_z` in 32 — core status and result

## Operation
- States: IDLE, ISSUE, START, WAIT, CAPTURE, DRAIN.
- `req_ready` = (state==IDLE) & buffer not full & !`core_busy`.
- The sequencer holds at most one request in flight.
- Classification on acceptance in IDLE:
  - NaN operand → quiet NaN: sign and payload of `a` if `a` is NaN, else of `b`; bit 22 forced to 1; invalid=1.
  - 0/0 or ∞/∞ → 0x7FC00000, invalid=1.
  - x/0 with x finite non-zero → {sign, 0xFF, 0}, divbyzero=1.
  - ∞/finite → signed ∞.
  - 0/x or finite/∞ → signed zero.
  - sign = a[31]^b[31] for all non-NaN cases.
  - Fast-path results are written to the buffer on the accept edge; the state stays IDLE.
- Otherwise (both finite, non-zero; subnormals included):
  - Accept edge latches operands and tag → ISSUE.
  - ISSUE: `core_enable`=1, operands driven.
  - START: `core_start`=1 for exactly one cycle.
  - WAIT: counter runs. `core_busy` must rise within START_WAIT cycles, then fall within TIMEOUT_CYCLES.
  - Busy falling → CAPTURE: `core_z` written to the buffer; overflow=1 if `core_z[30:23]`==0xFF.
  - CAPTURE → IDLE.
- Timeout (either bound exceeded):
  - Writes 0x7FC00000 with timeout=1.
  - Drops `core_enable` → DRAIN; DRAIN waits for `core_busy`=0, then → IDLE.
- CAPTURE or timeout while the buffer is full: hold state (with `core_enable` and operands unchanged) until a slot frees.
- Response buffer: 2-entry FIFO of {z, tag, flags}.
  - Simultaneous push and pop when full is allowed.
  - Pop occurs when `rsp_valid` & `rsp_ready`.

## Timing
- Reset values:
  - `req_ready`=0 during reset, then = !`core_busy`.
  - `rsp_valid`=0; `rsp_z`, `rsp_tag`, `rsp_flags` = 0.
  - `core_enable`, `core_start` = 0; `core_a`, `core_b` = 0.
  - State IDLE, buffer empty, counters 0.
- Fast path: accept at cycle T → `rsp_valid` at T+1 (empty buffer).
- Core path: accept at T, ISSUE T+1, START T+2, busy-low seen at cycle B → CAPTURE B+1 → `rsp_valid` at B+2.
- Back-to-back fast-path requests sustain 1 per cycle while the buffer drains.
- Reset during WAIT abandons the op (no response). The core's pending busy blocks `req_ready` until it clears.
- Responses return in acceptance order.

## Structure
- `fdiv_pkg`:
  - state enum;
  - QNAN_DEFAULT = 32'h7FC00000;
  - flag bit indices (INVALID=0, DIVBYZERO=1, OVERFLOW=2, TIMEOUT=3);
  - operand class enum (ZERO, SUB, NORM, INF, NAN).
- One sub-module, `fdiv_rsp_fifo`: 2-entry response FIFO, parameterised by width.
- Classification logic stays inline.

## Test plan
- 0x40C00000/0x40000000 (6/2), core model busy 8 cycles → `rsp_z`=0x40400000, flags 0, one `core_start` pulse, `rsp_valid` at B+2.
- 0x3F800000/0x00000000 → 0x7F800000, divbyzero=1, no `core_start`, `rsp_valid` at T+1.
- 0/0 → 0x7FC00000 invalid=1; 0x7F800001/0x3F800000 → 0x7FC00001 invalid=1.
- `rsp_ready`=0, three fast-path requests (tags 1, 2, 3) → two buffered, `req_ready` low; tag 3 accepted the cycle after first pop; tags return 1, 2, 3.
- Core model holds busy forever → after TIMEOUT_CYCLES, 0x7FC00000 with timeout=1; `req_ready` stays 0 until busy released.
- `rst` pulse during WAIT with busy held 5 more cycles → no response emitted, `req_ready`=0 for those 5 cycles, then 1.
